// File: rtl/reset_request_gen.sv
// Pushbutton reset requester: synchronizes and debounces an active-low button,
// issues a fixed-width reset request after a long hold, or a short-press pulse.
module reset_request_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int HOLD_CYCLES     = 100,
    parameter int PULSE_CYCLES    = 8,
    parameter int COOLDOWN_CYCLES = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic rst_req,
    output logic short_press,
    output logic pressed,
    output logic busy
);

    localparam logic [15:0] DEB    = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] DEB_M1 = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HLD    = 16'(HOLD_CYCLES);
    localparam logic [15:0] PLS    = 16'(PULSE_CYCLES);
    localparam logic [15:0] CDN    = 16'(COOLDOWN_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        PULSE,
        WAIT_RELEASE,
        COOLDOWN
    } state_t;

    state_t                 state;
    logic [15:0]            cnt;
    logic [15:0]            cnt_inc;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;

    // Synchronizer resets to all-ones so a reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], btn_n};
    end

    assign btn_s   = ~sync[SYNC_STAGES-1];
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // NOTE: every state register here uses <=, so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rst_req     <= 1'b0;
            short_press <= 1'b0;
            pressed     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            short_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DEBOUNCE;
                        cnt   <= 16'd1;
                        busy  <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DEB) begin
                        state   <= HOLD;
                        pressed <= 1'b1;
                        cnt     <= 16'd1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (!btn_s) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                        pressed     <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b0;
                    end else if (cnt == HLD) begin
                        state   <= PULSE;
                        rst_req <= 1'b1;
                        cnt     <= 16'd1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PULSE: begin
                    if (cnt == PLS) begin
                        state   <= WAIT_RELEASE;
                        rst_req <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_RELEASE: begin
                    // cnt holds the number of consecutive released samples seen so far.
                    if (btn_s) begin
                        cnt <= '0;
                    end else if (cnt == DEB_M1) begin
                        state   <= COOLDOWN;
                        pressed <= 1'b0;
                        cnt     <= 16'd1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                COOLDOWN: begin
                    if (cnt == CDN) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rst_req <= 1'b0;
                    pressed <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
